// File: rtl/pipeline_pkg.sv
// Shared pipeline types and widths for the instruction fetch stage.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RESET,
        WAIT,
        DELIVER
    } fetch_state_t;

    localparam int ADDR_W          = 16;
    localparam int WORD_W          = 32;
    localparam int LINE_W          = 64;
    localparam int LINE_OFFSET_W   = 3;
    localparam int TAG_W           = ADDR_W - LINE_OFFSET_W;
    localparam int MEM_LATENCY_DEF = 5;

endpackage

// File: rtl/instruction_fetch_if.sv
// Memory, redirect and IF/ID handshake signals of the fetch stage.
interface instruction_fetch_if;
    import pipeline_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_ins;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_ready;
    logic              instr_valid;
    logic [WORD_W-1:0] instr;
    logic [ADDR_W-1:0] pc_out;

    modport master (
        output mem_addr, instr_valid, instr, pc_out,
        input  mem_ins, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  mem_addr, instr_valid, instr, pc_out,
        output mem_ins, redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_line_buffer.sv
// Single-line fetch buffer: captured line, its tag, a tag-hit comparator
// and the low/high word select.
module fetch_line_buffer
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic [LINE_W-1:0] line_in,
    input  logic [TAG_W-1:0]  capture_tag,
    input  logic [TAG_W-1:0]  lookup_tag,
    input  logic              sel_hi,
    output logic              hit,
    output logic [WORD_W-1:0] word
);

    logic [LINE_W-1:0] line_buf;
    logic [TAG_W-1:0]  line_tag;
    logic              line_valid;

    // NOTE: line_buf is a flip-flop register, not a RAM macro, so it can take
    // the async reset; a real memory array would be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_buf   <= '0;
            line_tag   <= '0;
            line_valid <= 1'b0;
        end else if (capture) begin
            line_buf   <= line_in;
            line_tag   <= capture_tag;
            line_valid <= 1'b1;
        end
    end

    assign hit  = line_valid && (lookup_tag == line_tag);
    assign word = sel_hi ? line_buf[LINE_W-1:WORD_W] : line_buf[WORD_W-1:0];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding line access, two-word delivery
// over valid/ready, and redirects that reuse the buffered line when they hit.
module instruction_fetch
    import pipeline_pkg::*;
#(
    parameter int unsigned       MEM_LATENCY = MEM_LATENCY_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000
) (
    input logic                 clk,
    input logic                 rst_n,
    instruction_fetch_if.master bus
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 2);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next, pc_inc, target_pc, mem_addr;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_next;
    logic [TAG_W-1:0]  lookup_tag;
    logic              hit, capture, keep_waiting, delivering;
    logic [WORD_W-1:0] word;

    assign pc_inc     = pc + ADDR_W'(4);
    assign target_pc  = bus.redirect_pc & ~ADDR_W'(3);
    assign lookup_tag = bus.redirect_valid ? target_pc[ADDR_W-1:LINE_OFFSET_W]
                                           : pc_inc[ADDR_W-1:LINE_OFFSET_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RESET;
            pc       <= RESET_PC;
            mem_addr <= {RESET_PC[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            mem_addr <= {pc_next[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
            wait_cnt <= wait_cnt_next;
        end
    end

    // The reset cycle counts as the first cycle of the access to RESET_PC.
    always_comb begin
        // NOTE: every variable gets its default before any branch so no path
        // leaves one unassigned and infers a latch.
        state_next    = state;
        pc_next       = pc;
        wait_cnt_next = wait_cnt;
        keep_waiting  = 1'b0;
        capture       = 1'b0;

        if (bus.redirect_valid) begin
            pc_next = target_pc;
            if (hit) begin
                state_next = DELIVER;
            end else if (state != DELIVER &&
                         target_pc[ADDR_W-1:LINE_OFFSET_W] == mem_addr[ADDR_W-1:LINE_OFFSET_W]) begin
                keep_waiting = 1'b1;
            end else begin
                state_next    = WAIT;
                wait_cnt_next = '0;
            end
        end else begin
            unique case (state)
                RESET, WAIT: keep_waiting = 1'b1;
                DELIVER: begin
                    if (bus.id_ready) begin
                        pc_next = pc_inc;
                        if (!hit) begin
                            state_next    = WAIT;
                            wait_cnt_next = '0;
                        end
                    end
                end
                default: state_next = WAIT;
            endcase
        end

        if (keep_waiting) begin
            if (wait_cnt == CNT_W'(MEM_LATENCY)) begin
                capture    = 1'b1;
                state_next = DELIVER;
            end else begin
                wait_cnt_next = wait_cnt + 1'b1;
                state_next    = WAIT;
            end
        end
    end

    fetch_line_buffer u_line_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .capture     (capture),
        .line_in     (bus.mem_ins),
        .capture_tag (pc[ADDR_W-1:LINE_OFFSET_W]),
        .lookup_tag  (lookup_tag),
        .sel_hi      (pc[LINE_OFFSET_W-1]),
        .hit         (hit),
        .word        (word)
    );

    assign delivering      = (state == DELIVER);
    assign bus.mem_addr    = mem_addr;
    assign bus.instr_valid = delivering;
    assign bus.instr       = delivering ? word : '0;
    assign bus.pc_out      = delivering ? pc : '0;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the pipeline. It drives a line-aligned address into the instruction memory and waits out the memory's fixed access latency. It captures the 64-bit line and delivers its two 32-bit instructions, in order, to the IF/ID register under a valid/ready handshake. Redirects (branch/jump) restart the sequence, and a redirect that hits the buffered line is served without a new memory access.

## Interface
- `MEM_LATENCY`, default 5: number of memory access cycles. The line is captured one edge after the memory drives it.
- `RESET_PC`, default 16'h0000: PC loaded at reset. Must be word-aligned.
- `clk` in 1: system clock. Everything samples on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_addr` out 16: line address to the instruction memory, always {pc[15:3],3'b000}. Registered.
- `mem_ins` in 64: line from the instruction memory. Byte at line offset k is `mem_ins[8k+7:8k]`. Valid only on the capture edge.
- `redirect_valid` in 1: load a new PC this edge.
- `redirect_pc` in 16: target PC. Bits [1:0] are ignored and forced to 0.
- `id_ready` in 1: downstream accepts `instr` this edge.
- `instr_valid` out 1: `instr` and `pc_out` are valid.
- `instr` out 32: instruction at `pc_out`.
- `pc_out` out 16: PC of `instr`.

## Operation
- States:
  - RESET: entered asynchronously while `rst_n` is low.
  - WAIT: memory access in flight.
  - DELIVER: buffered line is being presented downstream.
- Reset values:
  - pc = `RESET_PC`, `mem_addr` = {RESET_PC[15:3],3'b000}.
  - wait_cnt = 0, line_valid = 0, line_buf = 0, line_tag = 0.
  - `instr_valid` = 0, `instr` = 0, `pc_out` = 0.
  - First clocked state is WAIT.
- WAIT:
  - wait_cnt increments each edge.
  - On the edge where wait_cnt == `MEM_LATENCY`:
    - line_buf ← `mem_ins`, line_tag ← pc[15:3], line_valid ← 1.
    - Go to DELIVER.
- `mem_addr` is held constant for the whole of WAIT. The memory restarts its access on any address change.
- DELIVER:
  - `instr_valid` = 1.
  - `instr` = pc[2] ? line_buf[63:32] : line_buf[31:0].
  - `pc_out` = pc.
- Transfer occurs on an edge with `instr_valid` && `id_ready`. Then pc ← pc+4 (16-bit wrap, 0xFFFC → 0x0000), and:
  - if the new pc[15:3] == line_tag, stay in DELIVER;
  - otherwise issue: `mem_addr` ← new line, wait_cnt ← 0, go to WAIT, `instr_valid` drops next cycle.
- While `id_ready` is low, `instr`, `pc_out` and `instr_valid` hold unchanged.
- Redirect (any state, priority over a same-edge transfer; the transfer is dropped, not completed). First pc ← {redirect_pc[15:2],2'b00}, then:
  - if line_valid and target line == line_tag: go to DELIVER next edge, no memory access;
  - else if in WAIT and target line == `mem_addr`[15:3]: keep waiting, wait_cnt not reset;
  - else issue a new line: wait_cnt ← 0, go to WAIT.
- No prefetch: at most one memory access is outstanding.

## Timing
- Issue edge E0 updates `mem_addr`. The memory produces the line after E0+`MEM_LATENCY`. Capture happens at E0+`MEM_LATENCY`+1 (E6 at default).
- `instr_valid` rises in the cycle after the capture edge.
- After reset release, the first capture is the 6th rising edge (default). Instruction at `RESET_PC` is valid from the 6th edge onward.
- Sequential throughput at `id_ready`=1, line-aligned start: 2 instructions per 8 cycles.
  - 1 DELIVER cycle for the low word.
  - 1 DELIVER cycle for the high word.
  - 6 WAIT cycles for the next line.
- Redirect hitting the buffered line: target instruction is valid the cycle after the redirect edge.
- Reset asserted mid-WAIT or mid-DELIVER: immediate return to reset values. The pending access is abandoned.

## Structure
- Shared package `pipeline_pkg` holds:
  - `fetch_state_t` enum {RESET, WAIT, DELIVER};
  - `ADDR_W`=16, `WORD_W`=32, `LINE_W`=64, `LINE_OFFSET_W`=3;
  - default `MEM_LATENCY`=5.
- Sub-module `fetch_line_buffer`: line_buf, line_tag and line_valid registers, the tag comparator (hit output) and the word-select mux.
- FSM, PC and wait counter stay in the top module.

## Test plan
- Reset release with `RESET_PC`=0, memory bytes 0..7 = 0..7, `id_ready`=1:
  - `instr_valid` rises after edge 6 with `instr`=32'h03020100, `pc_out`=0;
  - next cycle `instr`=32'h07060504, `pc_out`=4;
  - then `mem_addr`=0x0008 and `instr_valid`=0 for 6 cycles.
- `id_ready` low for 4 cycles at `pc_out`=0: `instr`/`pc_out` stable, no `mem_addr` change. `pc_out`=4 is delivered the cycle after `id_ready` rises.
- `redirect_pc`=0x0006 while the line for 0x0000 is buffered: next cycle `instr`=32'h07060504, `pc_out`=4, `mem_addr` unchanged.
- `redirect_pc`=0x0040 in WAIT, cycle 3 of the access for 0x0008: `mem_addr`=0x0040 next edge, wait_cnt restarts, capture 6 edges later, `pc_out`=0x0040.
- `redirect_pc`=0xFFFC, then two transfers: `pc_out`=0xFFFC, followed by `mem_addr`=0x0000, a 6-cycle wait, and `pc_out`=0x0000.
- `rst_n` pulsed low during DELIVER: outputs go to reset values immediately, and the `RESET_PC` sequence repeats from edge 6.
